// File: rtl/mac_pkg.sv
// Shared types and constants for the mac_accum dot-product accumulator.
package mac_pkg;

  typedef enum logic [1:0] {
    PREC_Q1_6  = 2'd0,
    PREC_Q1_14 = 2'd1,
    PREC_Q1_30 = 2'd2
  } prec_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } mac_state_e;

  // Left shifts that bring each product format onto the Q1.30 grid
  localparam int unsigned SHIFT_Q1_6  = 24;
  localparam int unsigned SHIFT_Q1_14 = 16;
  localparam int unsigned SHIFT_Q1_30 = 0;

  localparam logic signed [31:0] Q30_MAX = 32'sh7FFF_FFFF;
  localparam logic signed [31:0] Q30_MIN = 32'sh8000_0000;

endpackage

// File: rtl/q_align.sv
// Picks the product stream named by prec and aligns it, sign-extended, to Q1.30 at ACC_W bits.
module q_align
  import mac_pkg::*;
#(
  parameter int unsigned ACC_W = 40
) (
  input  logic [1:0]              prec,
  input  logic [7:0]              q1_6_in,
  input  logic                    q1_6_valid,
  input  logic [15:0]             q1_14_in,
  input  logic                    q1_14_valid,
  input  logic [31:0]             q1_30_in,
  input  logic                    q1_30_valid,
  output logic signed [ACC_W-1:0] aligned_c,
  output logic                    valid_c
);

  always_comb begin
    aligned_c = '0;
    valid_c   = 1'b0;
    case (prec_e'(prec))
      PREC_Q1_6: begin
        aligned_c = ACC_W'($signed(q1_6_in)) <<< SHIFT_Q1_6;
        valid_c   = q1_6_valid;
      end
      PREC_Q1_14: begin
        aligned_c = ACC_W'($signed(q1_14_in)) <<< SHIFT_Q1_14;
        valid_c   = q1_14_valid;
      end
      default: begin
        aligned_c = ACC_W'($signed(q1_30_in)) <<< SHIFT_Q1_30;
        valid_c   = q1_30_valid;
      end
    endcase
  end

endmodule

// File: rtl/mac_accum.sv
// Dot-product accumulator: sums vec_len aligned products in a guard-bit register and
// presents the saturated Q1.30 result on a valid/ready output.
module mac_accum
  import mac_pkg::*;
#(
  parameter int unsigned ACC_W = 40,
  parameter int unsigned LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       prec_sel,
  input  logic [LEN_W-1:0] vec_len,
  input  logic [7:0]       q1_6_in,
  input  logic             q1_6_valid,
  input  logic [15:0]      q1_14_in,
  input  logic             q1_14_valid,
  input  logic [31:0]      q1_30_in,
  input  logic             q1_30_valid,
  output logic             busy,
  output logic [31:0]      acc_out,
  output logic             sat,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(Q30_MAX);
  localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(Q30_MIN);

  mac_state_e              state;
  prec_e                   prec_q;
  logic [LEN_W-1:0]        len_q;
  logic [LEN_W-1:0]        cnt;
  logic signed [ACC_W-1:0] acc;

  logic signed [ACC_W-1:0] aligned_c;
  logic                    prod_valid_c;
  logic signed [ACC_W-1:0] sum_c;
  logic [LEN_W-1:0]        cnt_next_c;
  logic [31:0]             sat_val_c;
  logic                    sat_flag_c;

  q_align #(.ACC_W(ACC_W)) u_align (
    .prec        (prec_q),
    .q1_6_in     (q1_6_in),
    .q1_6_valid  (q1_6_valid),
    .q1_14_in    (q1_14_in),
    .q1_14_valid (q1_14_valid),
    .q1_30_in    (q1_30_in),
    .q1_30_valid (q1_30_valid),
    .aligned_c   (aligned_c),
    .valid_c     (prod_valid_c)
  );

  // Running sum including the current product, clipped once to Q1.30 for the output register
  always_comb begin
    sum_c      = acc + aligned_c;
    cnt_next_c = cnt + LEN_W'(1);
    sat_val_c  = sum_c[31:0];
    sat_flag_c = 1'b0;
    if (sum_c > SAT_HI) begin
      sat_val_c  = Q30_MAX;
      sat_flag_c = 1'b1;
    end else if (sum_c < SAT_LO) begin
      sat_val_c  = Q30_MIN;
      sat_flag_c = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      prec_q    <= PREC_Q1_30;
      len_q     <= '0;
      cnt       <= '0;
      acc       <= '0;
      acc_out   <= '0;
      sat       <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            prec_q <= (prec_sel == 2'd3) ? PREC_Q1_30 : prec_e'(prec_sel);
            len_q  <= vec_len;
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            if (vec_len != '0) begin
              state <= ACCUM;
            end else begin
              acc_out   <= '0;
              sat       <= 1'b0;
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        ACCUM: begin
          if (prod_valid_c) begin
            acc <= sum_c;
            cnt <= cnt_next_c;
            if (cnt_next_c == len_q) begin
              acc_out   <= sat_val_c;
              sat       <= sat_flag_c;
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_accum.sv
// Randomized scoreboard bench for mac_accum against an arithmetic dot-product model.
module tb_mac_accum;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  prec_sel;
  logic [7:0]  vec_len;
  logic [7:0]  q1_6_in;
  logic        q1_6_valid;
  logic [15:0] q1_14_in;
  logic        q1_14_valid;
  logic [31:0] q1_30_in;
  logic        q1_30_valid;
  logic        busy;
  logic [31:0] acc_out;
  logic        sat;
  logic        out_valid;
  logic        out_ready;

  int n_checks = 0;
  int n_fail   = 0;
  logic [32:0] sb_q[$];

  mac_accum #(.ACC_W(40), .LEN_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .prec_sel    (prec_sel),
    .vec_len     (vec_len),
    .q1_6_in     (q1_6_in),
    .q1_6_valid  (q1_6_valid),
    .q1_14_in    (q1_14_in),
    .q1_14_valid (q1_14_valid),
    .q1_30_in    (q1_30_in),
    .q1_30_valid (q1_30_valid),
    .busy        (busy),
    .acc_out     (acc_out),
    .sat         (sat),
    .out_valid   (out_valid),
    .out_ready   (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Value of one raw product in units of 2^-30
  function automatic longint real_val(input int p, input logic [31:0] raw);
    case (p)
      0:       return longint'($signed(raw[7:0])) * 64'sd16777216;
      1:       return longint'($signed(raw[15:0])) * 64'sd65536;
      default: return longint'($signed(raw));
    endcase
  endfunction

  // Expected {sat, acc_out} of a dot product: exact sum, clipped to the Q1.30 range
  function automatic logic [32:0] model(input int p, input logic [31:0] vals[$]);
    longint s = 0;
    foreach (vals[i]) s += real_val(p, vals[i]);
    if (s > 64'sd2147483647)       return {1'b1, 32'h7FFF_FFFF};
    else if (s < -64'sd2147483648) return {1'b1, 32'h8000_0000};
    else                           return {1'b0, s[31:0]};
  endfunction

  // Selected stream gets (v, d); the other streams carry random traffic
  task automatic drive(input int p, input logic v, input logic [31:0] d);
    q1_6_valid  = 1'($urandom_range(0, 1));
    q1_6_in     = 8'($urandom);
    q1_14_valid = 1'($urandom_range(0, 1));
    q1_14_in    = 16'($urandom);
    q1_30_valid = 1'($urandom_range(0, 1));
    q1_30_in    = 32'($urandom);
    case (p)
      0: begin q1_6_valid = v;  q1_6_in = d[7:0];   end
      1: begin q1_14_valid = v; q1_14_in = d[15:0]; end
      default: begin q1_30_valid = v; q1_30_in = d; end
    endcase
  endtask

  task automatic idle_inputs();
    q1_6_valid  = 1'b0;
    q1_14_valid = 1'b0;
    q1_30_valid = 1'b0;
  endtask

  task automatic run_dot(input int p, input int len, input logic [31:0] vals[$],
                         input int max_gap, input int hold);
    logic [32:0] exp;
    exp = model(p, vals);
    sb_q.push_back(exp);
    @(posedge clk); #1;
    start    = 1'b1;
    prec_sel = 2'(p);
    vec_len  = 8'(len);
    idle_inputs();
    for (int i = 0; i < len; i++) begin
      repeat ($urandom_range(0, max_gap)) begin
        @(posedge clk); #1;
        start = 1'b0;
        drive(p, 1'b0, 32'($urandom));
      end
      @(posedge clk); #1;
      start = 1'b0;
      drive(p, 1'b1, vals[i]);
    end
    // Result registered one cycle after the last sampled product; late products are dropped
    @(posedge clk); #1;
    start = 1'b0;
    drive(p, 1'($urandom_range(0, 1)), 32'($urandom));
    check("latency_out_valid", 64'(out_valid), 64'd1);
    check("busy_in_done", 64'(busy), 64'd1);
    for (int h = 0; h < hold; h++) begin
      start = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      check("hold_out_valid", 64'(out_valid), 64'd1);
      check("hold_acc_out", 64'(acc_out), 64'(exp[31:0]));
      check("hold_sat", 64'(sat), 64'(exp[32]));
      drive(p, 1'($urandom_range(0, 1)), 32'($urandom));
    end
    out_ready = 1'b1;
    start     = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    out_ready = 1'b0;
    start     = 1'b0;
    idle_inputs();
    check("post_hs_out_valid", 64'(out_valid), 64'd0);
    check("post_hs_busy", 64'(busy), 64'd0);
  endtask

  // Monitor: every accepted result must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_result", 64'(out_valid), 64'd0);
      end else begin
        logic [32:0] e;
        e = sb_q.pop_front();
        check("acc_out", 64'(acc_out), 64'(e[31:0]));
        check("sat", 64'(sat), 64'(e[32]));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] vals[$];
    rst_n = 1'b0; start = 1'b0; prec_sel = 2'd0; vec_len = 8'd0;
    q1_6_in = '0; q1_14_in = '0; q1_30_in = '0;
    q1_6_valid = 1'b0; q1_14_valid = 1'b0; q1_30_valid = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_acc_out", 64'(acc_out), 64'd0);
    check("rst_sat", 64'(sat), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;

    vals = '{32'h2000_0000, 32'h2000_0000, 32'h2000_0000, 32'h2000_0000};
    run_dot(2, 4, vals, 0, 0);
    vals = '{32'h20, 32'hE0};
    run_dot(0, 2, vals, 1, 0);
    vals = '{32'h4000, 32'h4000, 32'h4000};
    run_dot(1, 3, vals, 0, 0);
    vals = '{32'h8000_0000, 32'h8000_0000};
    run_dot(2, 2, vals, 0, 1);
    vals = '{32'h1000, 32'h2000, 32'hF000};
    run_dot(1, 3, vals, 2, 5);
    vals = '{};
    run_dot(0, 0, vals, 0, 2);
    vals = '{32'h1234_5678};
    run_dot(3, 1, vals, 0, 0);

    // Reset in the middle of a sum discards it immediately
    @(posedge clk); #1;
    start = 1'b1; prec_sel = 2'd2; vec_len = 8'd4;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      drive(2, 1'b1, 32'h1000_0000);
    end
    @(posedge clk); #1;
    idle_inputs();
    rst_n = 1'b0;
    #1;
    check("midrst_acc_out", 64'(acc_out), 64'd0);
    check("midrst_sat", 64'(sat), 64'd0);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    vals = '{32'h1, 32'h2};
    run_dot(2, 2, vals, 0, 0);

    for (int r = 0; r < 30; r++) begin
      int p;
      int len;
      p   = int'($urandom_range(0, 3));
      len = int'($urandom_range(0, 10));
      vals = '{};
      for (int i = 0; i < len; i++) vals.push_back(32'($urandom));
      run_dot(p, len, vals, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
    end

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
